seg_monitor: RTL and testbench

- Receiving end of the two-digit seven-segment display interface driven by the team's 0–99 counter blocks.
- Samples the active-low HEX0/HEX1 segment buses and decodes them back to a binary value 0–99.
- Checks that the observed sequence is one a legal up-counter can produce, and flags illegal glyphs, sequence breaks and 99→0 wraps.
- Used as an on-board self-test and as a bench checker beside any counter that drives HEX0/HEX1.

---
 rtl/seg_monitor.sv | 140 ++++++++++++++
 tb/tb_seg_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg_monitor.sv
// ============================================================================
// Module   : seg_monitor
// Purpose  : Decodes a two-digit active-low seven-segment bus back to 0-99 and
//            checks that the observed sequence is a legal up-counter sequence.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_monitor #(
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    output logic [6:0]       value,
    output logic             valid,
    output logic             locked,
    output logic             digit_err,
    output logic             seq_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;
    localparam logic [6:0]       c_MAX_VAL = 7'd99;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_prev_ok;

    logic [4:0] w_dec0;
    logic [4:0] w_dec1;
    logic       w_legal;
    logic [6:0] w_n;
    logic [6:0] w_succ;
    logic       w_perm;
    logic       w_dig_ev;
    logic       w_seq_ev;
    logic       w_wrap_ev;

    // Returns {legal, digit[3:0]} for one active-low glyph (bit6=g .. bit0=a).
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: f_decode = 5'b1_0000;
            7'b1111001: f_decode = 5'b1_0001;
            7'b0100100: f_decode = 5'b1_0010;
            7'b0110000: f_decode = 5'b1_0011;
            7'b0011001: f_decode = 5'b1_0100;
            7'b0010010: f_decode = 5'b1_0101;
            7'b0000010: f_decode = 5'b1_0110;
            7'b1111000: f_decode = 5'b1_0111;
            7'b0000000: f_decode = 5'b1_1000;
            7'b0010000: f_decode = 5'b1_1001;
            default:    f_decode = 5'b0_0000;
        endcase
    endfunction

    assign w_dec0  = f_decode(HEX0);
    assign w_dec1  = f_decode(HEX1);
    assign w_legal = w_dec0[4] & w_dec1[4];
    assign w_n     = ({3'b000, w_dec1[3:0]} * 7'd10) + {3'b000, w_dec0[3:0]};
    assign w_succ  = value + 7'd1;
    assign w_perm  = (w_n == value) || (w_n == w_succ) || (w_n == 7'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_dig_ev    = 1'b0;
        w_seq_ev    = 1'b0;
        w_wrap_ev   = 1'b0;
        if (en) begin
            if (!w_legal) begin
                w_dig_ev    = 1'b1;
                w_state_nxt = UNLOCKED;
            end else begin
                w_wrap_ev = r_prev_ok && (value == c_MAX_VAL) && (w_n == 7'd0);
                case (r_state)
                    UNLOCKED: begin
                        if (r_prev_ok && w_perm)
                            w_state_nxt = LOCKED;
                    end
                    LOCKED: begin
                        if (!w_perm) begin
                            w_seq_ev    = 1'b1;
                            w_state_nxt = UNLOCKED;
                        end
                    end
                    default: w_state_nxt = UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n)
            r_state <= UNLOCKED;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            value     <= 7'd0;
            valid     <= 1'b0;
            r_prev_ok <= 1'b0;
            digit_err <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            // Event strobes are all zero when en is low, so pulses self-clear.
            digit_err <= w_dig_ev;
            seq_err   <= w_seq_ev;
            wrap      <= w_wrap_ev;
            if (en) begin
                if (!w_legal) begin
                    valid     <= 1'b0;
                    r_prev_ok <= 1'b0;
                end else begin
                    value     <= w_n;
                    valid     <= 1'b1;
                    r_prev_ok <= 1'b1;
                end
                if ((w_dig_ev || w_seq_ev) && (err_cnt != c_ERR_MAX))
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign locked = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_seg_monitor.sv
// ============================================================================
// Module   : tb_seg_monitor
// Purpose  : Directed and randomized checking of seg_monitor against a model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_monitor;

    localparam int ERR_W = 8;

    logic             CLK;
    logic             rst_n;
    logic             en;
    logic [6:0]       HEX0;
    logic [6:0]       HEX1;
    logic [6:0]       value;
    logic             valid;
    logic             locked;
    logic             digit_err;
    logic             seq_err;
    logic             wrap;
    logic [ERR_W-1:0] err_cnt;

    seg_monitor #(.ERR_W(ERR_W)) u_dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .en        (en),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .value     (value),
        .valid     (valid),
        .locked    (locked),
        .digit_err (digit_err),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .err_cnt   (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state.
    int m_value, m_valid, m_locked, m_prev_ok, m_dig, m_seq, m_wrap, m_err;
    int wrap_seen;

    task automatic check(input string tag, input int obs, input int exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: glyph = 7'b1000000;
            1: glyph = 7'b1111001;
            2: glyph = 7'b0100100;
            3: glyph = 7'b0110000;
            4: glyph = 7'b0011001;
            5: glyph = 7'b0010010;
            6: glyph = 7'b0000010;
            7: glyph = 7'b1111000;
            8: glyph = 7'b0000000;
            default: glyph = 7'b0010000;
        endcase
    endfunction

    function automatic int seg2dig(input logic [6:0] s);
        seg2dig = -1;
        for (int d = 0; d < 10; d++)
            if (glyph(d) == s) seg2dig = d;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic [6:0] h0, input logic [6:0] h1);
        int o, t, n, perm;
        if (!r) begin
            m_value = 0; m_valid = 0; m_locked = 0; m_prev_ok = 0;
            m_dig = 0; m_seq = 0; m_wrap = 0; m_err = 0;
            return;
        end
        m_dig = 0; m_seq = 0; m_wrap = 0;
        if (!e) return;
        o = seg2dig(h0);
        t = seg2dig(h1);
        if (o < 0 || t < 0) begin
            m_dig = 1; m_valid = 0; m_prev_ok = 0; m_locked = 0;
            if (m_err < (1 << ERR_W) - 1) m_err++;
            return;
        end
        n = 10 * t + o;
        perm = (n == m_value) || (n == m_value + 1) || (n == 0);
        m_wrap = (m_prev_ok && m_value == 99 && n == 0) ? 1 : 0;
        if (!m_locked) begin
            if (m_prev_ok && perm) m_locked = 1;
        end else if (!perm) begin
            m_seq = 1; m_locked = 0;
            if (m_err < (1 << ERR_W) - 1) m_err++;
        end
        m_prev_ok = 1;
        m_value = n;
        m_valid = 1;
    endtask

    task automatic step(input logic r, input logic e, input logic [6:0] h0, input logic [6:0] h1);
        rst_n = r; en = e; HEX0 = h0; HEX1 = h1;
        @(posedge CLK);
        model_update(r, e, h0, h1);
        #1;
        if (wrap === 1'b1) wrap_seen++;
        check("value",     int'(value),     m_value);
        check("valid",     int'(valid),     m_valid);
        check("locked",    int'(locked),    m_locked);
        check("digit_err", int'(digit_err), m_dig);
        check("seq_err",   int'(seq_err),   m_seq);
        check("wrap",      int'(wrap),      m_wrap);
        check("err_cnt",   int'(err_cnt),   m_err);
    endtask

    task automatic show(input int n);
        step(1'b1, 1'b1, glyph(n % 10), glyph(n / 10));
    endtask

    initial begin
        int cur, sel;
        logic [6:0] g0, g1;
        rst_n = 1'b0; en = 1'b0; HEX0 = 7'h7F; HEX1 = 7'h7F;
        wrap_seen = 0;
        m_value = 0; m_valid = 0; m_locked = 0; m_prev_ok = 0;
        m_dig = 0; m_seq = 0; m_wrap = 0; m_err = 0;

        // Full count 00..99,00
        step(1'b0, 1'b1, glyph(5), glyph(5));
        step(1'b0, 1'b0, 7'h7F, 7'h7F);
        for (int i = 0; i < 100; i++) show(i);
        show(0);
        check("p1_wrap_count", wrap_seen, 1);
        check("p1_err_cnt", int'(err_cnt), 0);

        // Pauses, then en=0 with garbage
        show(36); show(37);
        for (int i = 0; i < 5; i++) show(37);
        show(38);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'h7F, 7'($urandom));
        check("p2_hold_value", int'(value), 38);

        // Sequence break and relock
        show(41); show(42); show(45); show(46);

        // Blank digit
        show(11); show(12);
        step(1'b1, 1'b1, 7'b1111111, glyph(1));
        show(13); show(14);

        // Clear without wrap, then saturation
        show(62); show(63); show(0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 7'b1111111, 7'b1111111);
        check("p5_err_sat", int'(err_cnt), 255);

        // Reset coinciding with a break
        show(50); show(51);
        step(1'b0, 1'b1, glyph(0), glyph(7));
        show(99); show(0);
        check("p6_locked", int'(locked), 1);

        // Randomized counter-like traffic
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      cur = (cur + 1) % 100;
            else if (sel < 85) cur = int'($urandom_range(0, 99));
            else if (sel < 88) cur = 0;
            g0 = glyph(cur % 10);
            g1 = glyph(cur / 10);
            if (sel >= 88 && sel < 93) begin
                if (sel[0]) g0 = 7'($urandom); else g1 = 7'($urandom);
            end
            step((sel == 99) ? 1'b0 : 1'b1, (sel >= 93 && sel < 98) ? 1'b0 : 1'b1, g0, g1);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

`default_nettype wire
